// File: rtl/coherence_pkg.sv
// rtl/coherence_pkg.sv - shared MSI coherence types, encodings and snoop transition function
package coherence_pkg;

    localparam int ADDR_W  = 3;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = 1;
    localparam int DATA_W  = 4;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_READ_MISS  = 2'b01,
        OP_WRITE_MISS = 2'b10,
        OP_INVALIDATE = 2'b11
    } snoop_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_DECIDE,
        ST_WRITEBACK,
        ST_UPDATE,
        ST_ACK
    } snoop_fsm_e;

    // A remote read demotes an owned line to S; any remote write intent kills it.
    function automatic logic [1:0] msi_snoop_next(input snoop_op_e op, input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = cur;
        case (cur)
            MSI_M, MSI_S: begin
                case (op)
                    OP_READ_MISS:                nxt = MSI_S;
                    OP_WRITE_MISS, OP_INVALIDATE: nxt = MSI_I;
                    default:                     nxt = cur;
                endcase
            end
            default: nxt = MSI_I;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - bus snoop responder: lookup, M-line writeback, MSI update, completion
module snoop_responder
    import coherence_pkg::*;
#(
    parameter logic CPU_ID = 1'b0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               snoop_valid,
    input  logic               snoop_src,
    input  logic [1:0]         snoop_op,
    input  logic [ADDR_W-1:0]  snoop_addr,
    output logic               snoop_ready,
    output logic               snoop_done,
    output logic               snoop_hit,
    output logic               snoop_abort,
    output logic [DATA_W-1:0]  snoop_data,
    output logic [INDEX_W-1:0] cache_index,
    input  logic [TAG_W-1:0]   cache_tag,
    input  logic [1:0]         cache_state,
    input  logic [DATA_W-1:0]  cache_data,
    output logic               state_we,
    output logic [1:0]         state_new,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack
);

    snoop_fsm_e          state_q, state_d;
    snoop_op_e           op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                hit_q, hit_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          new_state_q, new_state_d;
    logic                line_valid;
    logic                line_hit;

    // Encoding 11 is not a legal MSI state and must read as a miss.
    assign line_valid = (cache_state == MSI_S) || (cache_state == MSI_M);
    assign line_hit   = (cache_tag == addr_q[ADDR_W-1]) && line_valid;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            hit_q       <= 1'b0;
            abort_q     <= 1'b0;
            data_q      <= '0;
            new_state_q <= MSI_I;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            hit_q       <= hit_d;
            abort_q     <= abort_d;
            data_q      <= data_d;
            new_state_q <= new_state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        hit_d       = hit_q;
        abort_d     = abort_q;
        data_d      = data_q;
        new_state_d = new_state_q;
        case (state_q)
            ST_IDLE: begin
                if (snoop_valid) begin
                    op_d    = snoop_op_e'(snoop_op);
                    addr_d  = snoop_addr;
                    hit_d   = 1'b0;
                    abort_d = 1'b0;
                    data_d  = '0;
                    if ((snoop_src == CPU_ID) || (snoop_op_e'(snoop_op) == OP_NOP)) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: state_d = ST_DECIDE;
            ST_DECIDE: begin
                hit_d       = line_hit;
                data_d      = cache_data;
                new_state_d = msi_snoop_next(op_q, cache_state);
                if (!line_hit) begin
                    state_d = ST_ACK;
                end else if (cache_state == MSI_M) begin
                    state_d = ST_WRITEBACK;
                end else if (op_q != OP_READ_MISS) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack) begin
                    abort_d = 1'b1;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign snoop_ready = (state_q == ST_IDLE);
    assign snoop_done  = (state_q == ST_ACK);
    assign snoop_hit   = snoop_done && hit_q;
    assign snoop_abort = snoop_done && abort_q;
    assign snoop_data  = (snoop_done && abort_q) ? data_q : '0;
    assign cache_index = addr_q[INDEX_W-1:0];
    assign state_we    = (state_q == ST_UPDATE);
    assign state_new   = state_we ? new_state_q : MSI_I;
    assign mem_we      = (state_q == ST_WRITEBACK);
    assign mem_addr    = mem_we ? addr_q : '0;
    assign mem_wdata   = mem_we ? data_q : '0;

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - directed self-checking bench for snoop_responder
module tb_snoop_responder;

    logic       clock;
    logic       reset_n;
    logic       snoop_valid;
    logic       snoop_src;
    logic [1:0] snoop_op;
    logic [2:0] snoop_addr;
    logic       snoop_ready;
    logic       snoop_done;
    logic       snoop_hit;
    logic       snoop_abort;
    logic [3:0] snoop_data;
    logic [1:0] cache_index;
    logic       cache_tag;
    logic [1:0] cache_state;
    logic [3:0] cache_data;
    logic       state_we;
    logic [1:0] state_new;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       mem_ack;

    logic       tag_m   [4];
    logic [1:0] state_m [4];
    logic [3:0] data_m  [4];

    int n_checks = 0;
    int n_fail   = 0;

    int         done_k, swe_k, mwe_k;
    logic       r_hit, r_abort;
    logic [3:0] r_data, r_wdata;
    logic [1:0] r_snew;
    logic [2:0] r_maddr;
    int         done_seen;

    snoop_responder #(.CPU_ID(1'b0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .snoop_valid (snoop_valid),
        .snoop_src   (snoop_src),
        .snoop_op    (snoop_op),
        .snoop_addr  (snoop_addr),
        .snoop_ready (snoop_ready),
        .snoop_done  (snoop_done),
        .snoop_hit   (snoop_hit),
        .snoop_abort (snoop_abort),
        .snoop_data  (snoop_data),
        .cache_index (cache_index),
        .cache_tag   (cache_tag),
        .cache_state (cache_state),
        .cache_data  (cache_data),
        .state_we    (state_we),
        .state_new   (state_new),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cache array stub with one-cycle registered read.
    always @(posedge clock) begin
        cache_tag   <= tag_m[cache_index];
        cache_state <= state_m[cache_index];
        cache_data  <= data_m[cache_index];
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_line(input int idx, input logic t, input logic [1:0] st, input logic [3:0] d);
        tag_m[idx]   = t;
        state_m[idx] = st;
        data_m[idx]  = d;
    endtask

    // Issue one message and record when each strobe first appears, counted in
    // edges after the acceptance edge. done_k stays 0 if no completion arrives.
    task automatic run_msg(input logic src, input logic [1:0] op, input logic [2:0] addr, input int ack_n);
        int wb;
        wb = 0;
        done_k = 0; swe_k = 0; mwe_k = 0;
        r_hit = 0; r_abort = 0; r_data = 0; r_snew = 0; r_maddr = 0; r_wdata = 0;
        @(negedge clock);
        snoop_valid = 1'b1;
        snoop_src   = src;
        snoop_op    = op;
        snoop_addr  = addr;
        @(posedge clock);
        #1 snoop_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (state_we && swe_k == 0) begin
                swe_k  = k;
                r_snew = state_new;
            end
            if (mem_we && mwe_k == 0) begin
                mwe_k   = k;
                r_maddr = mem_addr;
                r_wdata = mem_wdata;
            end
            if (mem_we) begin
                wb++;
                mem_ack = (wb >= ack_n);
            end else begin
                mem_ack = 1'b0;
            end
            if (snoop_done) begin
                done_k  = k;
                r_hit   = snoop_hit;
                r_abort = snoop_abort;
                r_data  = snoop_data;
                break;
            end
            @(posedge clock);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        snoop_valid = 1'b0;
        snoop_src   = 1'b0;
        snoop_op    = 2'b00;
        snoop_addr  = 3'd0;
        mem_ack     = 1'b0;
        for (int i = 0; i < 4; i++) set_line(i, 1'b0, 2'b00, 4'h0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_eq("reset_ready", snoop_ready, 1);
        check_eq("reset_outs", {snoop_done, snoop_hit, snoop_abort, snoop_data, cache_index,
                                state_we, state_new, mem_we, mem_addr, mem_wdata}, 0);

        // Own-source message is ignored.
        set_line(1, 1'b1, 2'b01, 4'h9);
        run_msg(1'b0, 2'b01, 3'd5, 1);
        check_eq("own_done_lat", done_k, 1);
        check_eq("own_hit", r_hit, 0);
        check_eq("own_state_we", swe_k, 0);
        check_eq("own_mem_we", mwe_k, 0);

        // NOP from a remote CPU is ignored.
        run_msg(1'b1, 2'b00, 3'd5, 1);
        check_eq("nop_done_lat", done_k, 1);
        check_eq("nop_hit", r_hit, 0);

        // S hit, READ_MISS: no state change.
        run_msg(1'b1, 2'b01, 3'd5, 1);
        check_eq("srd_done_lat", done_k, 3);
        check_eq("srd_flags", {r_hit, r_abort, r_data}, {1'b1, 1'b0, 4'h0});
        check_eq("srd_state_we", swe_k, 0);

        // S hit, WRITE_MISS: invalidate.
        run_msg(1'b1, 2'b10, 3'd5, 1);
        check_eq("swr_swe_lat", swe_k, 3);
        check_eq("swr_state_new", r_snew, 0);
        check_eq("swr_done_lat", done_k, 4);
        check_eq("swr_flags", {r_hit, r_abort, r_data}, {1'b1, 1'b0, 4'h0});
        check_eq("swr_mem_we", mwe_k, 0);

        // M hit, READ_MISS, ack in second writeback cycle.
        set_line(2, 1'b0, 2'b10, 4'hA);
        run_msg(1'b1, 2'b01, 3'd2, 2);
        check_eq("mrd_mwe_lat", mwe_k, 3);
        check_eq("mrd_mem_addr", r_maddr, 2);
        check_eq("mrd_mem_wdata", r_wdata, 4'hA);
        check_eq("mrd_swe_lat", swe_k, 5);
        check_eq("mrd_state_new", r_snew, 1);
        check_eq("mrd_done_lat", done_k, 6);
        check_eq("mrd_flags", {r_hit, r_abort, r_data}, {1'b1, 1'b1, 4'hA});

        // Tag mismatch against an M line.
        set_line(2, 1'b0, 2'b10, 4'hA);
        run_msg(1'b1, 2'b01, 3'd6, 1);
        check_eq("tagmiss_done_lat", done_k, 3);
        check_eq("tagmiss_hit", r_hit, 0);
        check_eq("tagmiss_mem_we", mwe_k, 0);

        // Illegal state encoding reads as a miss.
        set_line(3, 1'b0, 2'b11, 4'h7);
        run_msg(1'b1, 2'b10, 3'd3, 1);
        check_eq("illegal_done_lat", done_k, 3);
        check_eq("illegal_flags", {r_hit, r_abort, r_data, swe_k[3:0]}, 0);

        // INVALIDATE on an M line, immediate ack.
        set_line(0, 1'b1, 2'b10, 4'h5);
        run_msg(1'b1, 2'b11, 3'd4, 1);
        check_eq("minv_mwe_lat", mwe_k, 3);
        check_eq("minv_mem_addr", r_maddr, 4);
        check_eq("minv_swe_lat", swe_k, 4);
        check_eq("minv_state_new", r_snew, 0);
        check_eq("minv_done_lat", done_k, 5);
        check_eq("minv_flags", {r_hit, r_abort, r_data}, {1'b1, 1'b1, 4'h5});

        // Reset while stalled in writeback.
        set_line(2, 1'b0, 2'b10, 4'hA);
        @(negedge clock);
        snoop_valid = 1'b1;
        snoop_src   = 1'b1;
        snoop_op    = 2'b01;
        snoop_addr  = 3'd2;
        @(posedge clock);
        #1 snoop_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_wb_active", mem_we, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check_eq("rst_mem_we_drop", mem_we, 0);
        check_eq("rst_ready", snoop_ready, 1);
        check_eq("rst_no_done", snoop_done, 0);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (snoop_done || state_we || mem_we) done_seen++;
        end
        check_eq("rst_quiet", done_seen, 0);
        run_msg(1'b1, 2'b01, 3'd6, 1);
        check_eq("rst_fresh_done_lat", done_k, 3);
        check_eq("rst_fresh_hit", r_hit, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
